// File: rtl/option_feeder.sv
// option_feeder: producer side of the solver's per-axis option stream.
// A circular buffer holds groups laid out as an index word followed by that
// line's candidate options. The solver reads the head word, index words are
// recirculated automatically, and options the solver keeps are put back.
// Per-line option counts are committed each time a group is closed.
// Optional build macro: OPTION_FEEDER_STATS_EN adds pass_count and drop_count.
//
// Handshakes: a load word transfers on a clock edge where load_valid and
// load_ready are both high. The head word is valid while option_valid is
// high, and read_from_fifo pops it at the clock edge. put_back is a push
// with no back-pressure: if the buffer is full it is dropped and overflow set.
module option_feeder #(
    parameter int OPT_W     = 16,
    parameter int DEPTH     = 256,
    parameter int MAX_LINES = 11,
    parameter int AMNT_W    = 7,
    parameter int LINE_BASE = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_valid,
    input  logic                          load_is_index,
    input  logic [OPT_W-1:0]              load_word,
    output logic                          load_ready,
    input  logic                          start,
    output logic [OPT_W-1:0]              option,
    output logic                          option_valid,
    output logic                          option_is_index,
    input  logic                          read_from_fifo,
    input  logic                          put_back,
    input  logic [OPT_W-1:0]              new_option,
    output logic [MAX_LINES*AMNT_W-1:0]   old_options_amnt,
    output logic                          pass_stalled,
`ifdef OPTION_FEEDER_STATS_EN
    output logic [15:0]                   pass_count,
    output logic [15:0]                   drop_count,
`endif
    output logic                          overflow
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int LINE_W = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;
    localparam logic [OPT_W:0] BASE_EXT = (OPT_W + 1)'(LINE_BASE);

    localparam logic [0:0] S_LOAD = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]         state_q;
    logic [OPT_W:0]     mem [DEPTH];
    logic [CNT_W-1:0]   wr_ptr_q, rd_ptr_q, count;
    logic               hold_valid_q;
    logic [OPT_W-1:0]   hold_q;
    logic               grp_open_q;
    logic [AMNT_W-1:0]  grp_cnt_q;
    logic [LINE_W-1:0]  cur_line_q;
    logic [AMNT_W-1:0]  amnt_q [MAX_LINES];
    logic               seen_base_q, changed_q;

    logic               run, full, empty;
    logic [OPT_W:0]     head;
    logic [OPT_W-1:0]   pop_word;
    logic               pop, pop_idx, pb, ld;
    logic [OPT_W:0]     pop_off, ld_off;
    logic               pop_in_range, ld_in_range;
    logic               wr_req, wr_ok, drop, idx_to_hold, pb_ok;
    logic [OPT_W:0]     wr_data;
    logic [AMNT_W-1:0]  commit_val;
    logic               change_now, base_pop, pass_end;

    // Occupancy is the pointer distance; pointers carry one extra wrap bit.
    assign count = wr_ptr_q - rd_ptr_q;
    assign run   = (state_q == S_RUN);
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr_q[PTR_W-1:0]];
    assign pop_word = head[OPT_W-1:0];

    assign load_ready      = !run && !full;
    assign option_valid    = run && !empty;
    assign option          = option_valid ? pop_word : '0;
    assign option_is_index = option_valid ? head[OPT_W] : 1'b0;

    assign pop     = run && read_from_fifo && !empty;
    assign pop_idx = pop && head[OPT_W];
    assign pb      = run && put_back;
    assign ld      = !run && load_valid && !full;

    // Line offsets relative to this instance; the borrow bit flags words below the base.
    assign pop_off      = {1'b0, pop_word} - BASE_EXT;
    assign pop_in_range = !pop_off[OPT_W] && (pop_off[OPT_W-1:0] < OPT_W'(MAX_LINES));
    assign ld_off       = {1'b0, load_word} - BASE_EXT;
    assign ld_in_range  = !ld_off[OPT_W] && (ld_off[OPT_W-1:0] < OPT_W'(MAX_LINES));

    // Single write port: put_back wins, then a deferred index, then a fresh index.
    assign wr_req      = ld || pb || hold_valid_q || pop_idx;
    assign wr_ok       = wr_req && (!full || pop);
    assign drop        = wr_req && !wr_ok;
    assign idx_to_hold = pop_idx && (pb || hold_valid_q);
    assign pb_ok       = pb && wr_ok;

    // Select the word written at the tail this cycle.
    always_comb begin
        wr_data = '0;
        if (ld)                wr_data = {load_is_index, load_word};
        else if (pb)           wr_data = {1'b0, new_option};
        else if (hold_valid_q) wr_data = {1'b1, hold_q};
        else                   wr_data = {1'b1, pop_word};
    end

    // A put_back alongside an index pop still belongs to the group being closed.
    assign commit_val = grp_cnt_q + AMNT_W'(pb_ok);
    assign change_now = pop_idx && grp_open_q && (commit_val != amnt_q[cur_line_q]);
    assign base_pop   = pop_idx && (pop_word == OPT_W'(LINE_BASE));
    assign pass_end   = base_pop && seen_base_q;

    // Buffer storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr_q[PTR_W-1:0]] <= wr_data;
    end

    // FSM, pointers, index holding register and sticky overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_LOAD;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
            overflow     <= 1'b0;
        end else begin
            if (!run && start) state_q <= S_RUN;
            if (wr_ok) wr_ptr_q <= wr_ptr_q + CNT_W'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + CNT_W'(1);
            hold_valid_q <= idx_to_hold || (hold_valid_q && pb);
            if (idx_to_hold) hold_q <= pop_word;
            if (drop) overflow <= 1'b1;
        end
    end

    // Group tracking and per-line option counts (load-time tally, run-time commit).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grp_open_q <= 1'b0;
            grp_cnt_q  <= '0;
            cur_line_q <= '0;
            for (int i = 0; i < MAX_LINES; i++) amnt_q[i] <= '0;
        end else if (!run) begin
            if (ld && load_is_index) begin
                cur_line_q <= ld_off[LINE_W-1:0];
                grp_open_q <= ld_in_range;
            end else if (ld && grp_open_q) begin
                amnt_q[cur_line_q] <= amnt_q[cur_line_q] + AMNT_W'(1);
            end
            if (start) begin
                grp_open_q <= 1'b0;
                grp_cnt_q  <= '0;
            end
        end else if (pop_idx) begin
            if (grp_open_q) amnt_q[cur_line_q] <= commit_val;
            cur_line_q <= pop_off[LINE_W-1:0];
            grp_open_q <= pop_in_range;
            grp_cnt_q  <= '0;
        end else if (pb_ok) begin
            grp_cnt_q <= grp_cnt_q + AMNT_W'(1);
        end
    end

    // Pass boundary detection on the base index and stall flag update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seen_base_q  <= 1'b0;
            changed_q    <= 1'b0;
            pass_stalled <= 1'b0;
        end else if (base_pop) begin
            if (seen_base_q) pass_stalled <= !(changed_q || change_now);
            seen_base_q <= 1'b1;
            changed_q   <= 1'b0;
        end else if (change_now) begin
            changed_q <= 1'b1;
        end
    end

    for (genvar g = 0; g < MAX_LINES; g++) begin : g_amnt
        assign old_options_amnt[g*AMNT_W +: AMNT_W] = amnt_q[g];
    end

`ifdef OPTION_FEEDER_STATS_EN
    // Saturating pass and dropped-push counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pass_count <= '0;
            drop_count <= '0;
        end else begin
            if (pass_end && pass_count != 16'hFFFF) pass_count <= pass_count + 16'd1;
            if (drop && drop_count != 16'hFFFF)     drop_count <= drop_count + 16'd1;
        end
    end
`else
    logic unused_pass_end;
    assign unused_pass_end = pass_end;
`endif

endmodule

// File: tb/tb_option_feeder.sv
// Directed testbench for option_feeder (default parameters).
module tb_option_feeder;

    localparam int OPT_W     = 16;
    localparam int DEPTH     = 256;
    localparam int MAX_LINES = 11;
    localparam int AMNT_W    = 7;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        load_valid, load_is_index, start;
    logic [OPT_W-1:0]            load_word, new_option;
    logic                        read_from_fifo, put_back;
    logic                        load_ready, option_valid, option_is_index;
    logic [OPT_W-1:0]            option;
    logic [MAX_LINES*AMNT_W-1:0] old_options_amnt;
    logic                        pass_stalled, overflow;
`ifdef OPTION_FEEDER_STATS_EN
    logic [15:0]                 pass_count, drop_count;
`endif

    int tests = 0;
    int fails = 0;

    option_feeder dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_is_index(load_is_index),
        .load_word(load_word), .load_ready(load_ready), .start(start),
        .option(option), .option_valid(option_valid),
        .option_is_index(option_is_index),
        .read_from_fifo(read_from_fifo), .put_back(put_back),
        .new_option(new_option), .old_options_amnt(old_options_amnt),
        .pass_stalled(pass_stalled),
`ifdef OPTION_FEEDER_STATS_EN
        .pass_count(pass_count), .drop_count(drop_count),
`endif
        .overflow(overflow)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AMNT_W-1:0] amnt_of(input int i);
        return old_options_amnt[i*AMNT_W +: AMNT_W];
    endfunction

    task automatic clear_inputs();
        load_valid = 0; load_is_index = 0; load_word = '0; start = 0;
        read_from_fifo = 0; put_back = 0; new_option = '0;
    endtask

    task automatic do_reset(input string tag);
        rst = 0;
        clear_inputs();
        #1;
        check({tag, "_rst_option"}, option, 0);
        check({tag, "_rst_valid"}, option_valid, 0);
        check({tag, "_rst_load_ready"}, load_ready, 1);
        check({tag, "_rst_amnt"}, old_options_amnt, 0);
        tick();
        tick();
        rst = 1;
    endtask

    task automatic load(input logic is_idx, input logic [OPT_W-1:0] w);
        load_valid = 1; load_is_index = is_idx; load_word = w;
        tick();
        load_valid = 0; load_is_index = 0;
    endtask

    task automatic go();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic pop(input logic pb, input logic [OPT_W-1:0] nv);
        read_from_fifo = 1; put_back = pb; new_option = nv;
        tick();
        read_from_fifo = 0; put_back = 0;
    endtask

    task automatic push_only(input logic [OPT_W-1:0] nv);
        put_back = 1; new_option = nv;
        tick();
        put_back = 0;
    endtask

    initial begin
        int popped;
        int bad;

        // T1: index 0 with option 0x7FF, recirculation and commit
        do_reset("t1");
        load(1, 16'h0000);
        load(0, 16'h07FF);
        check("t1_load_amnt0", amnt_of(0), 1);
        check("t1_load_ready_load", load_ready, 1);
        go();
        check("t1_load_ready_run", load_ready, 0);
        check("t1_head_idx", {option_valid, option_is_index, option}, {2'b11, 16'h0000});
        pop(0, 0);
        check("t1_head_opt", {option_valid, option_is_index, option}, {2'b10, 16'h07FF});
        pop(1, 16'h07FF);
        check("t1_idx_recirc", {option_is_index, option}, {1'b1, 16'h0000});
        pop(0, 0);
        check("t1_amnt0_commit", amnt_of(0), 1);
        check("t1_stalled", pass_stalled, 1);
        check("t1_head_after", {option_is_index, option}, {1'b0, 16'h07FF});

        // T2: line 1 with three options, one survives
        do_reset("t2");
        load(1, 16'd1);
        load(0, 16'h000A);
        load(0, 16'h000B);
        load(0, 16'h000C);
        check("t2_load_amnt1", amnt_of(1), 3);
        go();
        pop(0, 0);
        pop(1, 16'h000A);
        pop(0, 0);
        pop(0, 0);
        check("t2_head_idx1", {option_is_index, option}, {1'b1, 16'd1});
        pop(0, 0);
        check("t2_amnt1", amnt_of(1), 1);
        check("t2_head_opt", {option_is_index, option}, {1'b0, 16'h000A});
        pop(1, 16'h000A);
        check("t2_head_idx_again", {option_valid, option_is_index, option}, {2'b11, 16'd1});
        check("t2_not_stalled", pass_stalled, 0);

        // T3: lines 0..10, one option each; stable pass then a pass with a drop
        do_reset("t3");
        for (int l = 0; l < MAX_LINES; l++) begin
            load(1, 16'(l));
            load(0, 16'(16'h0100 + l));
        end
        check("t3_load_amnt10", amnt_of(10), 1);
        go();
        for (int l = 0; l < MAX_LINES; l++) begin
            pop(0, 0);
            pop(1, 16'(16'h0100 + l));
        end
        check("t3_head_idx0", {option_is_index, option}, {1'b1, 16'h0000});
        pop(0, 0);
        check("t3_stalled_1", pass_stalled, 1);
        check("t3_amnt10", amnt_of(10), 1);
        pop(0, 0);  // drop option of line 0
        for (int l = 1; l < MAX_LINES; l++) begin
            pop(0, 0);
            pop(1, 16'(16'h0100 + l));
        end
        check("t3_head_idx0_b", {option_is_index, option}, {1'b1, 16'h0000});
        pop(0, 0);
        check("t3_stalled_0", pass_stalled, 0);
        check("t3_amnt0_zero", amnt_of(0), 0);
        check("t3_amnt5", amnt_of(5), 1);

        // T4: put_back in the same cycle as an index pop goes through the holding register
        do_reset("t4");
        load(1, 16'h0000);
        load(0, 16'h0011);
        load(0, 16'h0022);
        check("t4_load_amnt0", amnt_of(0), 2);
        go();
        pop(0, 0);
        pop(0, 0);
        pop(0, 0);
        check("t4_head_idx0", {option_is_index, option}, {1'b1, 16'h0000});
        pop(1, 16'h0033);
        check("t4_amnt0", amnt_of(0), 1);
        check("t4_stalled", pass_stalled, 0);
        check("t4_head_pb", {option_valid, option_is_index, option}, {2'b10, 16'h0033});
        pop(0, 0);
        check("t4_head_held_idx", {option_valid, option_is_index, option}, {2'b11, 16'h0000});
        check("t4_no_overflow", overflow, 0);

        // T5: fill to DEPTH, loads blocked, put_back while full is dropped
        do_reset("t5");
        for (int i = 0; i < DEPTH; i++) load(0, 16'(i));
        check("t5_full_load_ready", load_ready, 0);
        load(0, 16'hDEAD);
        check("t5_load_no_overflow", overflow, 0);
        go();
        push_only(16'hBEEF);
        check("t5_overflow", overflow, 1);
        push_only(16'hBEEF);
`ifdef OPTION_FEEDER_STATS_EN
        check("t5_drop_count", drop_count, 2);
`endif
        check("t5_head_first", {option_valid, option}, {1'b1, 16'h0000});
        popped = 0;
        bad = 0;
        for (int i = 0; i < DEPTH + 20; i++) begin
            if (!option_valid) break;
            if (option !== 16'(popped)) bad++;
            pop(0, 0);
            popped++;
        end
        check("t5_pop_count", popped, DEPTH);
        check("t5_pop_order_errors", bad, 0);
        check("t5_empty", option_valid, 0);

        // T6: asynchronous reset mid-RUN with a pop pending
        do_reset("t6");
        load(1, 16'h0000);
        load(0, 16'h0005);
        go();
        check("t6_pre_valid", option_valid, 1);
        read_from_fifo = 1;
        #2;
        rst = 0;
        #1;
        check("t6_async_valid", option_valid, 0);
        check("t6_async_option", {option_is_index, option}, 0);
        check("t6_async_load_ready", load_ready, 1);
        check("t6_async_amnt", old_options_amnt, 0);
        check("t6_async_flags", {pass_stalled, overflow}, 0);
        read_from_fifo = 0;
        tick();
        tick();
        rst = 1;
        load(1, 16'd2);
        load(0, 16'h0007);
        check("t6_reload_amnt2", amnt_of(2), 1);
        check("t6_reload_amnt0", amnt_of(0), 0);
        go();
        check("t6_reload_head", {option_valid, option_is_index, option}, {2'b11, 16'd2});

`ifdef OPTION_FEEDER_STATS_EN
        // T7: three completed passes
        do_reset("t7");
        load(1, 16'h0000);
        load(0, 16'h0009);
        go();
        pop(0, 0);
        for (int p = 0; p < 3; p++) begin
            pop(1, 16'h0009);
            pop(0, 0);
        end
        check("t7_pass_count", pass_count, 3);
        check("t7_drop_count", drop_count, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Overall time bound
    initial begin
        #200000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/option_feeder.md
Name: option_feeder

Overview:
- Producer side of the solver's per-axis option stream. One instance feeds rows, one feeds columns.
- Stores grouped option words in a circular buffer, laid out as: line-index word, then that line's candidate options.
- Presents the head word to the solver and pops it on the solver's read strobe.
- Re-enqueues index words automatically and options the solver puts back. Maintains per-line option counts (old_options_amnt) for the solver.

Parameters:
- OPT_W, 16, width of one option/index word
- DEPTH, 256, buffer entries (power of 2)
- MAX_LINES, 11, lines handled by this instance
- AMNT_W, 7, width of per-line option count
- LINE_BASE, 0, index value of this instance's first line (0 for rows, num_rows for columns)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- load_valid  in  1  load word present
- load_is_index  in  1  load word is a line index (starts a new group)
- load_word  in  OPT_W  load data
- load_ready  out  1  feeder accepts load word
- start  in  1  one-cycle pulse: end load, begin solving
- option  out  OPT_W  head word to solver
- option_valid  out  1  head word valid
- option_is_index  out  1  head word is a line index
- read_from_fifo  in  1  solver pops head word
- put_back  in  1  solver re-enqueues new_option
- new_option  in  OPT_W  option surviving this pass
- old_options_amnt  out  MAX_LINES*AMNT_W  per-line option count, line i at bits [i*AMNT_W +: AMNT_W]
- pass_stalled  out  1  full pass completed with no count change
- overflow  out  1  sticky, a push was dropped because the buffer was full

Behaviour:
- Storage: DEPTH x (OPT_W+1). Bit OPT_W is the index tag. Write pointer, read pointer, and count are all log2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
- Reset (rst=0, asynchronous):
  - state=LOAD; pointers and count = 0.
  - option=0, option_valid=0, option_is_index=0.
  - load_ready=1 (follows state and fullness).
  - all old_options_amnt = 0, pass_stalled=0, overflow=0.
- States: LOAD -> RUN on start. RUN -> LOAD only through reset. start while in RUN is ignored.
- LOAD:
  - load_ready = !full.
  - On load_valid&&load_ready, write {load_is_index, load_word} at tail.
  - Option words increment the count of the most recently loaded index line (load_word-LINE_BASE).
  - read_from_fifo and put_back are ignored; option_valid=0.
- RUN:
  - load_ready=0.
  - option/option_is_index are combinational from the head entry (first-word fall-through).
  - option_valid = (count != 0).
  - Pop in cycle N: the next word is visible in cycle N+1.
- Pop of an index word:
  - The feeder writes the same index word back to tail in the same cycle (auto-recirculate).
  - If a previous group was open, commit old_options_amnt[cur_line] <= grp_cnt.
  - Then cur_line <= word-LINE_BASE; grp_cnt <= 0.
- put_back:
  - Writes {0,new_option} to tail and increments grp_cnt.
  - Legal only while a group is open.
  - A put_back in the same cycle as an index auto-write has priority; the index write is delayed one cycle via a 1-entry holding register. The solver never issues both back-to-back.
- Pop of an option word without put_back discards it.
- Simultaneous pop+push: count unchanged. Pop with count=0: ignored. Push with full: dropped, overflow<=1.
- Pass tracking:
  - A pass ends when the index word with value LINE_BASE is popped a second time or later.
  - pass_stalled <= 1 if no old_options_amnt value changed during the pass; otherwise 0.
  - pass_stalled holds until the next pass ends.
- Index words outside LINE_BASE..LINE_BASE+MAX_LINES-1 are passed through but update no count.

Optional Feature:
- Macro: OPTION_FEEDER_STATS_EN.
- Defined: adds output pass_count (16 bits, reset 0). It increments at each pass end and saturates at 0xFFFF.
- Defined: adds output drop_count (16 bits, reset 0). It counts dropped pushes and saturates.
- Undefined: neither port nor its logic exists. All other behaviour is identical.

Test Plan:
- Load index 0 then 11'b11111111111; start; pop both -> option shows 0 (is_index=1), then 0x7FF; index 0 is re-enqueued; old_options_amnt[0]=1 after index 0 is popped again.
- Load line 1 with 3 options; in RUN, put back 1 of 3 -> on the next pop of index 1, old_options_amnt[1]=1, and the buffer holds index 1 plus 1 option.
- Lines 0..10, one option each, all put back -> after the second pop of index 0, pass_stalled=1; after a pass with one dropped option, pass_stalled=0.
- Fill to DEPTH in LOAD -> load_ready=0; force a put_back while full -> overflow=1 and count stays DEPTH.
- Assert rst low mid-RUN while a pop is pending -> all outputs return to reset values immediately; load restarts cleanly.
- With OPTION_FEEDER_STATS_EN: 3 passes and 2 dropped pushes -> pass_count=3, drop_count=2.
